// File: rtl/ram_b_pkg.sv
// Shared types and constants for the RAM_B two-port arbiter.
package ram_b_pkg;

  // Word address width (byte address bits [7:2]) and data width of RAM_B.
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  localparam logic [NB-1:0] BE_FULL = 4'b1111;
  localparam logic [NB-1:0] BE_NONE = 4'b0000;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    RMW_ADDR,
    RMW_MERGE,
    WR,
    NOP_ACK
  } state_t;

  // Identifies a requester: 0 or 1.
  typedef logic port_t;

  // The port that gets priority after a grant to p.
  function automatic port_t other_port(input port_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/ram_b_arbiter_if.sv
// Requester and RAM_B signals of the arbiter bundled as one interface.
// slave is the arbiter's view; master is the view of everything around it.
interface ram_b_arbiter_if;
  import ram_b_pkg::*;

  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [NB-1:0] be0, be1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          busy;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] m_w_data;
  logic [DW-1:0] m_r_data;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, be0, be1, wdata0, wdata1,
    input  m_r_data,
    output ack0, ack1, rdata0, rdata1, busy, mem_write, mem_addr, m_w_data
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, be0, be1, wdata0, wdata1,
    output m_r_data,
    input  ack0, ack1, rdata0, rdata1, busy, mem_write, mem_addr, m_w_data
  );

endinterface

// File: rtl/ram_b_byte_merge.sv
// Byte-lane merge for read-modify-write: lanes with be set come from
// new_word, the rest keep old_word.
module ram_b_byte_merge
  import ram_b_pkg::*;
(
  input  logic [DW-1:0] old_word,
  input  logic [DW-1:0] new_word,
  input  logic [NB-1:0] be,
  output logic [DW-1:0] merged
);

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign merged[8*gi +: 8] = be[gi] ? new_word[8*gi +: 8] : old_word[8*gi +: 8];
  end

endmodule

// File: rtl/ram_b_arbiter.sv
// Round-robin arbiter sharing the single-port RAM_B between two requesters.
// Partial writes are read-modify-write because RAM_B has a single wea bit.
module ram_b_arbiter
  import ram_b_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  ram_b_arbiter_if.slave bus
);

  state_t                 state;
  port_t                  ptr;
  port_t                  owner;
  logic [NB-1:0]          op_be;
  logic [DW-1:0]          op_wdata;
  logic [1:0]             ack_reg;
  logic [1:0][DW-1:0]     rdata_reg;
  logic                   mem_write_reg;
  logic [AW-1:0]          mem_addr_reg;
  logic [DW-1:0]          m_w_data_reg;

  logic                   grant_valid;
  port_t                  winner;
  logic                   sel_we;
  logic [AW-1:0]          sel_addr;
  logic [NB-1:0]          sel_be;
  logic [DW-1:0]          sel_wdata;
  logic [DW-1:0]          merged;

  // Pick the winner among the current requesters and mux its request fields.
  always_comb begin
    grant_valid = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      winner = ptr;
    end else if (bus.req1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
    sel_we    = winner ? bus.we1    : bus.we0;
    sel_addr  = winner ? bus.addr1  : bus.addr0;
    sel_be    = winner ? bus.be1    : bus.be0;
    sel_wdata = winner ? bus.wdata1 : bus.wdata0;
  end

  ram_b_byte_merge u_merge (
    .old_word (bus.m_r_data),
    .new_word (op_wdata),
    .be       (op_be),
    .merged   (merged)
  );

  // Arbiter FSM: grant in IDLE, sequence the RAM access, pulse the owner's ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      owner         <= 1'b0;
      op_be         <= '0;
      op_wdata      <= '0;
      ack_reg       <= '0;
      rdata_reg     <= '0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      m_w_data_reg  <= '0;
    end else begin
      ack_reg       <= '0;
      mem_write_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner        <= winner;
            ptr          <= other_port(winner);
            op_be        <= sel_be;
            op_wdata     <= sel_wdata;
            mem_addr_reg <= sel_addr;
            if (!sel_we) begin
              state <= RD_ADDR;
            end else if (sel_be == BE_FULL) begin
              // Whole word: write straight away, no read needed.
              state           <= WR;
              mem_write_reg   <= 1'b1;
              m_w_data_reg    <= sel_wdata;
              ack_reg[winner] <= 1'b1;
            end else if (sel_be == BE_NONE) begin
              state           <= NOP_ACK;
              ack_reg[winner] <= 1'b1;
            end else begin
              state <= RMW_ADDR;
            end
          end
        end
        RD_ADDR: begin
          // RAM samples mem_addr at this edge; data shows up in RD_DATA.
          ack_reg[owner] <= 1'b1;
          state          <= RD_DATA;
        end
        RD_DATA: begin
          rdata_reg[owner] <= bus.m_r_data;
          state            <= IDLE;
        end
        RMW_ADDR: begin
          state <= RMW_MERGE;
        end
        RMW_MERGE: begin
          m_w_data_reg   <= merged;
          mem_write_reg  <= 1'b1;
          ack_reg[owner] <= 1'b1;
          state          <= WR;
        end
        WR, NOP_ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data is forwarded straight from RAM_B in the ack cycle, then held.
  assign bus.rdata0 = (state == RD_DATA && owner == 1'b0) ? bus.m_r_data : rdata_reg[0];
  assign bus.rdata1 = (state == RD_DATA && owner == 1'b1) ? bus.m_r_data : rdata_reg[1];

  assign bus.ack0      = ack_reg[0];
  assign bus.ack1      = ack_reg[1];
  assign bus.busy      = (state != IDLE);
  assign bus.mem_write = mem_write_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.m_w_data  = m_w_data_reg;

endmodule

// File: doc/ram_b_arbiter.md
Name: ram_b_arbiter

Overview:
- Shares the single-port 64x32 RAM_B block RAM (one write enable, one-cycle registered read) between two requesters, port 0 and port 1.
- Round-robin arbitration with a req/ack handshake.
- Byte-enabled writes are done as read-modify-write, since RAM_B has only one wea bit.
- Sits between the requesters (e.g. CPU data path, test/LED front end) and the RAM_B instance.

Parameters:
- AW, 6, word address width; address bits [7:2].
- DW, 32, data width; fixed by RAM_B.

Ports:
- Clk  in  1  rising-edge clock, also drives RAM_B clka
- Rst  in  1  asynchronous, active-high reset
- Req0/Req1  in  1  request from port 0/1; held high until Ack
- We0/We1  in  1  1 = write, 0 = read
- Addr0/Addr1  in  [7:2]  word address
- BE0/BE1  in  4  byte enables, bit i = byte lane [8i+7:8i]; ignored on reads
- WData0/WData1  in  32  write data
- Ack0/Ack1  out  1  one-cycle completion pulse
- RData0/RData1  out  32  read data; valid in the Ack cycle and held until that port's next read completes
- Busy  out  1  1 whenever state != IDLE
- Mem_Write  out  1  to RAM_B wea; registered
- Mem_Addr  out  [7:2]  to RAM_B addra; registered
- M_W_Data  out  32  to RAM_B dina; registered
- M_R_Data  in  32  from RAM_B douta

Behaviour:
- Reset (async):
  - state = IDLE, priority pointer = port 0.
  - All outputs 0, including RData0/1, Mem_Write, Mem_Addr and M_W_Data.
  - Reset mid-operation aborts with no Ack. Mem_Write drops immediately. A write in flight may or may not land.
- Handshake:
  - Requester holds Req, We, Addr, BE and WData stable until its Ack.
  - Ack is exactly one cycle. Request signals are latched at grant, so later changes have no effect on the granted op.
  - Req still high in the cycle after Ack is a new request.
- Arbitration, in IDLE only:
  - One requester: it is granted.
  - Both requesting: the port named by the pointer wins.
  - After each grant the pointer moves to the other port.
  - Grant latches port id, We, Addr, BE and WData, and loads Mem_Addr.
- States: IDLE, RD_ADDR, RD_DATA, RMW_ADDR, RMW_MERGE, WR, NOP_ACK.
- Read (We=0): IDLE -> RD_ADDR -> RD_DATA.
  - RAM samples Mem_Addr at the end of RD_ADDR.
  - In RD_DATA, M_R_Data is captured into the winner's RData and Ack is pulsed, then return to IDLE.
  - Latency: Req seen in cycle 0, Ack in cycle 2.
- Full write (BE=4'b1111): IDLE -> WR.
  - Mem_Write=1 and M_W_Data=WData for exactly the WR cycle; Ack is pulsed in WR.
  - Ack in cycle 1.
- Partial write (BE not 0000 and not 1111): IDLE -> RMW_ADDR -> RMW_MERGE -> WR.
  - In RMW_MERGE, M_W_Data is registered as: byte i = WData byte i where BE[i]=1, else M_R_Data byte i.
  - Ack is pulsed in WR; Ack in cycle 3.
- Null write (BE=0000): IDLE -> NOP_ACK.
  - Ack is pulsed with no RAM access; Mem_Write stays 0.
- Mem_Write is 1 only in WR. Mem_Addr holds its last value in IDLE.
- Back-to-back:
  - From any terminal state, return to IDLE; arbitration happens the next cycle.
  - Minimum one IDLE cycle between operations.
- Both ports requesting continuously alternate strictly: 0, 1, 0, 1, ...
- A read of an address written by the immediately preceding op returns the new data. No bypass is needed, because the write lands before the read's RD_ADDR edge.

Decomposition:
- Package ram_b_pkg holds:
  - state enum
  - AW/DW constants
  - BE_FULL = 4'b1111 and BE_NONE = 4'b0000
  - port-id typedef (1 bit)
- Sub-module ram_b_byte_merge: combinational (old[31:0], new[31:0], be[3:0]) -> merged[31:0].
- The arbiter FSM, pointer and latches stay in ram_b_arbiter.

Test Plan:
- Port0 full write Addr=6'h01, WData=32'h1234_5678, BE=1111, then read 6'h01 -> Ack0 in cycle 1 with Mem_Write high for one cycle; read Ack0 in cycle 2 with RData0=32'h1234_5678.
- Word 6'h02 preloaded with 32'hffff_ffff; port1 writes WData=32'h0002_0603 with BE=0101, then reads -> Ack1 in cycle 3 with exactly one Mem_Write cycle; RData1=32'hff02_ff03.
- Req0 and Req1 both held high for 4 operations starting from reset -> grant order 0, 1, 0, 1; no Ack overlap; each Ack one cycle wide.
- Port0 write with BE=0000 to 6'h03 (holding 32'h0002_0003) -> Ack0 in cycle 1, Mem_Write never asserted; later read returns 32'h0002_0003.
- Rst asserted during RMW_MERGE -> all outputs 0 asynchronously, no Ack; after release the next request is served from IDLE with the pointer at port 0.
- Port0 read with Addr toggled after grant -> RData0 is the data at the address latched at grant.
